// File: rtl/ctrl_pkg.sv
// Shared decode vocabulary for the ID control stage: opcodes, exe_cmd codes,
// branch encoding and the control bundle carried from decode to the output register.
package ctrl_pkg;

    localparam int unsigned OP_NOP  = 0;
    localparam int unsigned OP_ADD  = 1;
    localparam int unsigned OP_SUB  = 3;
    localparam int unsigned OP_MUL  = 4;
    localparam int unsigned OP_AND  = 5;
    localparam int unsigned OP_OR   = 6;
    localparam int unsigned OP_NOR  = 7;
    localparam int unsigned OP_XOR  = 8;
    localparam int unsigned OP_SLA  = 9;
    localparam int unsigned OP_SLL  = 10;
    localparam int unsigned OP_SRA  = 11;
    localparam int unsigned OP_SRL  = 12;
    localparam int unsigned OP_ADDI = 32;
    localparam int unsigned OP_SUBI = 33;
    localparam int unsigned OP_LD   = 36;
    localparam int unsigned OP_ST   = 37;
    localparam int unsigned OP_BEZ  = 40;
    localparam int unsigned OP_BNE  = 41;
    localparam int unsigned OP_JMP  = 42;

    localparam int CMD_W = 4;
    typedef logic [CMD_W-1:0] cmd_t;

    localparam cmd_t CMD_ADD = 4'd0;
    localparam cmd_t CMD_SUB = 4'd2;
    localparam cmd_t CMD_MUL = 4'd3;
    localparam cmd_t CMD_AND = 4'd4;
    localparam cmd_t CMD_OR  = 4'd5;
    localparam cmd_t CMD_NOR = 4'd6;
    localparam cmd_t CMD_XOR = 4'd7;
    localparam cmd_t CMD_SHL = 4'd8;
    localparam cmd_t CMD_SRA = 4'd9;
    localparam cmd_t CMD_SRL = 4'd10;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEZ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_JMP  = 2'b11
    } br_t;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic wb_en;
        logic is_imm;
        br_t  branch_type;
        cmd_t exe_cmd;
        logic illegal;
    } ctrl_t;

    // Register-writing ALU operation; memory and branch fields stay clear.
    function automatic ctrl_t alu_ctrl(input cmd_t cmd, input logic imm);
        ctrl_t c;
        c         = '0;
        c.exe_cmd = cmd;
        c.wb_en   = 1'b1;
        c.is_imm  = imm;
        return c;
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Opcode to control-bundle lookup; MUL (opcode 4) is decoded only when MULT_EN is defined.
// Latency: purely combinational.
// Backpressure: none, the caller owns all handshaking.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int OPC_W = 6
) (
    input  logic [OPC_W-1:0] opcode,
    output ctrl_t            ctrl,
    output logic             src2_used
);

    always_comb begin
        ctrl      = '0;
        src2_used = 1'b0;
        case (32'(opcode))
            OP_NOP: ;
            OP_ADD: begin ctrl = alu_ctrl(CMD_ADD, 1'b0); src2_used = 1'b1; end
            OP_SUB: begin ctrl = alu_ctrl(CMD_SUB, 1'b0); src2_used = 1'b1; end
`ifdef MULT_EN
            OP_MUL: begin ctrl = alu_ctrl(CMD_MUL, 1'b0); src2_used = 1'b1; end
`endif
            OP_AND: begin ctrl = alu_ctrl(CMD_AND, 1'b0); src2_used = 1'b1; end
            OP_OR:  begin ctrl = alu_ctrl(CMD_OR,  1'b0); src2_used = 1'b1; end
            OP_NOR: begin ctrl = alu_ctrl(CMD_NOR, 1'b0); src2_used = 1'b1; end
            OP_XOR: begin ctrl = alu_ctrl(CMD_XOR, 1'b0); src2_used = 1'b1; end
            OP_SLA, OP_SLL: begin ctrl = alu_ctrl(CMD_SHL, 1'b0); src2_used = 1'b1; end
            OP_SRA: begin ctrl = alu_ctrl(CMD_SRA, 1'b0); src2_used = 1'b1; end
            OP_SRL: begin ctrl = alu_ctrl(CMD_SRL, 1'b0); src2_used = 1'b1; end
            OP_ADDI: ctrl = alu_ctrl(CMD_ADD, 1'b1);
            OP_SUBI: ctrl = alu_ctrl(CMD_SUB, 1'b1);
            OP_LD: begin
                ctrl          = alu_ctrl(CMD_ADD, 1'b1);
                ctrl.mem_read = 1'b1;
            end
            // Store reads src2 as the data operand, so it joins the src2 hazard check.
            OP_ST: begin
                ctrl           = alu_ctrl(CMD_ADD, 1'b1);
                ctrl.wb_en     = 1'b0;
                ctrl.mem_write = 1'b1;
                src2_used      = 1'b1;
            end
            OP_BEZ: ctrl.branch_type = BR_BEZ;
            OP_BNE: ctrl.branch_type = BR_BNE;
            OP_JMP: ctrl.branch_type = BR_JMP;
            default: ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ctrl_stage.sv
// ID control stage: decode, load-use bubble insertion, flush, optional MUL issue FSM (MULT_EN).
// Latency: an accepted instruction appears on the registered outputs one cycle after acceptance.
// Backpressure: in_ready drops on load-use hazard, during reset and while a MUL waits out MUL_LAT.
module id_ctrl_stage
    import ctrl_pkg::*;
#(
    parameter int OPC_W   = 6,
    parameter int REG_W   = 5,
    parameter int EXE_W   = 4,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OPC_W-1:0] opcode,
    input  logic [REG_W-1:0] src1,
    input  logic [REG_W-1:0] src2,
    input  logic [REG_W-1:0] dest,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_dest,
    input  logic             flush,
    output logic             out_valid,
    output logic             mem_read,
    output logic             mem_write,
    output logic             wb_en,
    output logic             is_imm,
    output logic [1:0]       branch_type,
    output logic [EXE_W-1:0] exe_cmd,
    output logic [REG_W-1:0] dest_out,
    output logic             stall,
    output logic             illegal
);

    if (MUL_LAT < 2) begin : g_bad_mul_lat
        $error("id_ctrl_stage: MUL_LAT must be at least 2");
    end

    ctrl_t dec;
    logic  src2_used;
    ctrl_t ctrl_q;
    logic  hazard;
    logic  keep_dest;
    logic  ld_dec;

    ctrl_decode #(.OPC_W(OPC_W)) u_decode (
        .opcode    (opcode),
        .ctrl      (dec),
        .src2_used (src2_used)
    );

    assign hazard = in_valid & ex_mem_read & (ex_dest != '0) &
                    ((ex_dest == src1) | ((ex_dest == src2) & src2_used));

    // NOP and undefined opcodes carry no destination downstream.
    assign keep_dest = ~dec.illegal & (opcode != '0);

`ifdef MULT_EN
    typedef enum logic {MUL_IDLE, MUL_BUSY} mul_state_t;
    localparam int CNT_W = $clog2(MUL_LAT);

    mul_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic [REG_W-1:0] mul_dest;
    logic             is_mul;
    logic             idle;
    logic             mul_start;

    assign is_mul    = (32'(opcode) == OP_MUL);
    assign idle      = (state == MUL_IDLE);
    assign mul_start = ~flush & idle & in_valid & is_mul & ~hazard;
    assign ld_dec    = ~flush & idle & in_valid & ~is_mul & ~hazard;
    // The MUL is only accepted in the last busy cycle, when it is also issued.
    assign in_ready  = ~rst & (flush | (idle ? (~hazard & ~(in_valid & is_mul)) : (cnt == '0)));
    assign stall     = ~rst & ~flush & idle & hazard;
`else
    assign ld_dec    = ~flush & in_valid & ~hazard;
    assign in_ready  = ~rst & (flush | ~hazard);
    assign stall     = ~rst & ~flush & hazard;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ctrl_q    <= '0;
            dest_out  <= '0;
`ifdef MULT_EN
            state     <= MUL_IDLE;
            cnt       <= '0;
            mul_dest  <= '0;
`endif
        end else begin
            out_valid <= ld_dec;
            ctrl_q    <= ld_dec ? dec : ctrl_t'('0);
            dest_out  <= (ld_dec & keep_dest) ? dest : '0;
`ifdef MULT_EN
            if (flush) begin
                state <= MUL_IDLE;
                cnt   <= '0;
            end else if (mul_start) begin
                state    <= MUL_BUSY;
                cnt      <= CNT_W'(MUL_LAT - 2);
                mul_dest <= dest;
            end else if (state == MUL_BUSY) begin
                if (cnt == '0) begin
                    state     <= MUL_IDLE;
                    out_valid <= 1'b1;
                    ctrl_q    <= alu_ctrl(CMD_MUL, 1'b0);
                    dest_out  <= mul_dest;
                end else begin
                    cnt <= cnt - CNT_W'(1);
                end
            end
`endif
        end
    end

    assign mem_read    = ctrl_q.mem_read;
    assign mem_write   = ctrl_q.mem_write;
    assign wb_en       = ctrl_q.wb_en;
    assign is_imm      = ctrl_q.is_imm;
    assign branch_type = ctrl_q.branch_type;
    assign exe_cmd     = EXE_W'(ctrl_q.exe_cmd);
    assign illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_id_ctrl_stage.sv
// Directed bench for id_ctrl_stage: vector table for decode/hazard/flush, plus reset and MUL sequences.
module tb_id_ctrl_stage;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [5:0] opcode;
    logic [4:0] src1, src2, dest;
    logic       ex_mem_read;
    logic [4:0] ex_dest;
    logic       flush;
    logic       out_valid, mem_read, mem_write, wb_en, is_imm;
    logic [1:0] branch_type;
    logic [3:0] exe_cmd;
    logic [4:0] dest_out;
    logic       stall;
    logic       illegal;

    int errors = 0;
    int checks = 0;

    id_ctrl_stage #(.OPC_W(6), .REG_W(5), .EXE_W(4), .MUL_LAT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .src1        (src1),
        .src2        (src2),
        .dest        (dest),
        .ex_mem_read (ex_mem_read),
        .ex_dest     (ex_dest),
        .flush       (flush),
        .out_valid   (out_valid),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .wb_en       (wb_en),
        .is_imm      (is_imm),
        .branch_type (branch_type),
        .exe_cmd     (exe_cmd),
        .dest_out    (dest_out),
        .stall       (stall),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [5:0]  op;
        logic [4:0]  s1, s2, d;
        logic        emr;
        logic [4:0]  ed;
        logic        fl;
        logic        rdy;
        logic        stl;
        logic [16:0] exp;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] obs();
        return {out_valid, mem_read, mem_write, wb_en, is_imm, branch_type, exe_cmd, dest_out, illegal};
    endfunction

    function automatic logic [16:0] E(int v, int mr, int mw, int wb, int imm, int br, int cmd, int d, int ill);
        return {1'(v), 1'(mr), 1'(mw), 1'(wb), 1'(imm), 2'(br), 4'(cmd), 5'(d), 1'(ill)};
    endfunction

    function automatic logic [16:0] A(int cmd, int d);
        return E(1, 0, 0, 1, 0, 0, cmd, d, 0);
    endfunction

    function automatic vec_t V(int v, int op, int s1, int s2, int d, int emr, int ed, int fl,
                               int rdy, int stl, logic [16:0] exp);
        vec_t r;
        r.v = 1'(v);   r.op = 6'(op); r.s1 = 5'(s1); r.s2 = 5'(s2); r.d = 5'(d);
        r.emr = 1'(emr); r.ed = 5'(ed); r.fl = 1'(fl);
        r.rdy = 1'(rdy); r.stl = 1'(stl); r.exp = exp;
        return r;
    endfunction

    task automatic drive(input vec_t x);
        in_valid = x.v; opcode = x.op; src1 = x.s1; src2 = x.s2; dest = x.d;
        ex_mem_read = x.emr; ex_dest = x.ed; flush = x.fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t x, input string tag);
        drive(x);
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(x.rdy));
        chk({tag, "_stall"}, 32'(stall), 32'(x.stl));
        tick();
        chk({tag, "_out"}, 32'(obs()), 32'(x.exp));
    endtask

`ifdef MULT_EN
    // Inputs already hold a MUL with no hazard: expect three bubbles, then the issue.
    task automatic mul_wait_issue(input string tag, input int d);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("%s_wait%0d_in_ready", tag, k), 32'(in_ready), 32'(0));
            tick();
            chk($sformatf("%s_bubble%0d", tag, k), 32'(obs()), 32'(0));
        end
        chk({tag, "_last_in_ready"}, 32'(in_ready), 32'(1));
        tick();
        chk({tag, "_issue"}, 32'(obs()), 32'(E(1, 0, 0, 1, 0, 0, 3, d, 0)));
    endtask
`endif

    initial begin
        vt.push_back(V(1,  1, 1, 2,  3, 0, 0, 0, 1, 0, A(0, 3)));
        vt.push_back(V(1, 32, 1, 2,  4, 0, 0, 0, 1, 0, E(1, 0, 0, 1, 1, 0, 0, 4, 0)));
        vt.push_back(V(1, 37, 1, 2,  5, 0, 0, 0, 1, 0, E(1, 0, 1, 0, 1, 0, 0, 5, 0)));
        vt.push_back(V(1, 41, 1, 2,  6, 0, 0, 0, 1, 0, E(1, 0, 0, 0, 0, 2, 0, 6, 0)));
        vt.push_back(V(1,  3, 1, 2,  1, 0, 0, 0, 1, 0, A(2, 1)));
        vt.push_back(V(1,  5, 1, 2,  2, 0, 0, 0, 1, 0, A(4, 2)));
        vt.push_back(V(1,  6, 1, 2,  3, 0, 0, 0, 1, 0, A(5, 3)));
        vt.push_back(V(1,  7, 1, 2,  4, 0, 0, 0, 1, 0, A(6, 4)));
        vt.push_back(V(1,  8, 1, 2,  5, 0, 0, 0, 1, 0, A(7, 5)));
        vt.push_back(V(1,  9, 1, 2,  6, 0, 0, 0, 1, 0, A(8, 6)));
        vt.push_back(V(1, 10, 1, 2,  7, 0, 0, 0, 1, 0, A(8, 7)));
        vt.push_back(V(1, 11, 1, 2,  8, 0, 0, 0, 1, 0, A(9, 8)));
        vt.push_back(V(1, 12, 1, 2,  9, 0, 0, 0, 1, 0, A(10, 9)));
        vt.push_back(V(1, 33, 1, 2, 10, 0, 0, 0, 1, 0, E(1, 0, 0, 1, 1, 0, 2, 10, 0)));
        vt.push_back(V(1, 36, 1, 2, 11, 0, 0, 0, 1, 0, E(1, 1, 0, 1, 1, 0, 0, 11, 0)));
        vt.push_back(V(1, 40, 1, 2, 12, 0, 0, 0, 1, 0, E(1, 0, 0, 0, 0, 1, 0, 12, 0)));
        vt.push_back(V(1, 42, 1, 2, 13, 0, 0, 0, 1, 0, E(1, 0, 0, 0, 0, 3, 0, 13, 0)));
        vt.push_back(V(1, 63, 1, 2,  9, 0, 0, 0, 1, 0, E(1, 0, 0, 0, 0, 0, 0, 0, 1)));
        vt.push_back(V(1,  0, 1, 2,  9, 0, 0, 0, 1, 0, E(1, 0, 0, 0, 0, 0, 0, 0, 0)));
        vt.push_back(V(0,  1, 1, 2,  3, 0, 0, 0, 1, 0, '0));
        vt.push_back(V(1,  1, 7, 2,  3, 1, 7, 0, 0, 1, '0));
        vt.push_back(V(1,  1, 7, 2,  3, 0, 7, 0, 1, 0, A(0, 3)));
        vt.push_back(V(1,  1, 0, 0,  3, 1, 0, 0, 1, 0, A(0, 3)));
        vt.push_back(V(1,  1, 1, 7,  3, 1, 7, 0, 0, 1, '0));
        vt.push_back(V(1, 32, 1, 7,  4, 1, 7, 0, 1, 0, E(1, 0, 0, 1, 1, 0, 0, 4, 0)));
        vt.push_back(V(1, 37, 1, 7,  5, 1, 7, 0, 0, 1, '0));
        vt.push_back(V(1,  1, 7, 2,  3, 1, 7, 1, 1, 0, '0));
        vt.push_back(V(1, 36, 1, 2, 11, 0, 0, 1, 1, 0, '0));
        vt.push_back(V(1,  1, 1, 2,  3, 0, 0, 0, 1, 0, A(0, 3)));
`ifndef MULT_EN
        vt.push_back(V(1,  4, 1, 2,  8, 0, 0, 0, 1, 0, E(1, 0, 0, 0, 0, 0, 0, 0, 1)));
`endif

        // Reset held two cycles while an ADD is offered.
        rst = 1'b1;
        drive(V(1, 1, 1, 2, 3, 0, 0, 0, 0, 0, '0));
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'(0));
        tick();
        tick();
        chk("reset_out", 32'(obs()), 32'(0));
        chk("reset_in_ready_held", 32'(in_ready), 32'(0));
        chk("reset_stall", 32'(stall), 32'(0));
        rst = 1'b0;

        foreach (vt[i]) apply(vt[i], $sformatf("vec%0d", i));

`ifdef MULT_EN
        drive(V(1, 4, 1, 2, 8, 0, 0, 0, 0, 0, '0));
        mul_wait_issue("mul", 8);

        // Load-use stall first; stall cycles must not count toward MUL_LAT.
        drive(V(1, 4, 1, 2, 9, 1, 1, 0, 0, 0, '0));
        #1;
        chk("mul_haz_stall", 32'(stall), 32'(1));
        chk("mul_haz_in_ready", 32'(in_ready), 32'(0));
        tick();
        chk("mul_haz_bubble", 32'(obs()), 32'(0));
        ex_mem_read = 1'b0;
        mul_wait_issue("mul_after_stall", 9);

        // Flush while the second bubble is on the outputs aborts the MUL.
        drive(V(1, 4, 1, 2, 8, 0, 0, 0, 0, 0, '0));
        tick();
        tick();
        flush = 1'b1;
        #1;
        chk("mul_flush_in_ready", 32'(in_ready), 32'(1));
        chk("mul_flush_stall", 32'(stall), 32'(0));
        tick();
        chk("mul_flush_bubble", 32'(obs()), 32'(0));
        flush = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("mul_flush_idle%0d_in_ready", k), 32'(in_ready), 32'(1));
            tick();
            chk($sformatf("mul_flush_idle%0d_out", k), 32'(obs()), 32'(0));
        end
        apply(V(1, 1, 1, 2, 3, 0, 0, 0, 1, 0, A(0, 3)), "post_flush_add");

        // Reset in the middle of a MUL: nothing may issue afterwards.
        drive(V(1, 4, 1, 2, 8, 0, 0, 0, 0, 0, '0));
        tick();
        rst = 1'b1;
        #1;
        chk("mul_rst_in_ready", 32'(in_ready), 32'(0));
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("mul_rst_idle%0d_out", k), 32'(obs()), 32'(0));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ctrl_stage.md
ID_CTRL_STAGE -- requirements
Module: id_ctrl_stage

Interface
REQ-001 Parameter OPC_W, default 6, opcode width.
REQ-002 Parameter REG_W, default 5, register-address width.
REQ-003 Parameter EXE_W, default 4, exe_cmd width.
REQ-004 Parameter MUL_LAT, default 4, multiply issue latency in cycles (>=2).
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 in_valid  in  1; in_ready  out  1; fetch-side handshake, transfer when both high.
REQ-008 opcode  in  OPC_W; src1, src2, dest  in  REG_W each.
REQ-009 ex_mem_read  in  1; ex_dest  in  REG_W; instruction currently in EXE.
REQ-010 flush  in  1  branch taken in EXE, kill younger instruction.
REQ-011 out_valid, mem_read, mem_write, wb_en, is_imm  out  1; branch_type  out  2; exe_cmd  out  EXE_W; dest_out  out  REG_W; all registered.
REQ-012 stall  out  1  load-use bubble inserted this cycle; illegal  out  1  registered one-cycle pulse on undefined opcode.

Function
REQ-013 Decode table: ADD 1->cmd 0; SUB 3->2; AND 5->4; OR 6->5; NOR 7->6; XOR 8->7; SLA 9/SLL 10->8; SRA 11->9; SRL 12->10; all wb_en=1, is_imm=0.
REQ-014 ADDI 32->cmd 0, SUBI 33->cmd 2; is_imm=1, wb_en=1.
REQ-015 LD 36: cmd 0, is_imm=1, mem_read=1, wb_en=1; ST 37: cmd 0, is_imm=1, mem_write=1, wb_en=0.
REQ-016 BEZ 40/BNE 41/JMP 42: branch_type 01/10/11, wb_en=0, no memory access; branch_type=00 otherwise.
REQ-017 Opcode 0 = NOP: all controls 0, out_valid=1, illegal=0; any other undefined opcode: all controls 0, out_valid=1, illegal=1.
REQ-018 Every accepted instruction appears on outputs exactly 1 cycle after acceptance.
REQ-019 Bubble = out_valid=0, all controls 0, dest_out=0.
REQ-020 Load-use hazard: in_valid & ex_mem_read & ex_dest!=0 & (ex_dest==src1 | (ex_dest==src2 & opcode is R-type or ST)) -> in_ready=0, stall=1, bubble loaded; hazard clears next cycle.
REQ-021 in_valid=0 with no flush -> bubble loaded, in_ready=1.
REQ-022 flush has priority over stall and multiply: bubble loaded, in_ready=1, offered instruction dropped, MUL FSM returns to IDLE.
REQ-023 in_ready, stall combinational from current inputs and state; outputs never change except on clk edge.

Reset
REQ-024 rst high: output register = bubble, illegal=0, FSM IDLE, counter 0; in_ready=0 while rst high.
REQ-025 rst mid-multiply aborts it; no MUL issues after reset.

Configuration
REQ-026 Macro MULT_EN defined: opcode 4 = MUL, cmd 3, wb_en=1; FSM IDLE->BUSY on acceptance-attempt, holds in_ready=0 and emits bubbles for MUL_LAT-1 cycles (counter down), then issues MUL and returns IDLE.
REQ-027 MULT_EN undefined: opcode 4 is undefined (REQ-017), no FSM or counter in netlist.
REQ-028 Load-use stall is evaluated before MUL entry; stall cycles do not count toward MUL_LAT.

Structure
REQ-029 Package ctrl_pkg holds opcode constants, exe_cmd constants, branch_type encoding, and the control-bundle struct.
REQ-030 Sub-module ctrl_decode: purely combinational opcode->bundle table; id_ctrl_stage holds register, hazard logic, MUL FSM.

Verification
REQ-031 Reset: rst=1 two cycles -> out_valid=0, all controls 0, in_ready=0, illegal=0.
REQ-032 Stream ADD,ADDI 32,ST 37,BNE 41 back-to-back -> next cycles exe_cmd 0/0/0/x, is_imm 0/1/1/0, mem_write 0/0/1/0, branch_type 00/00/00/10.
REQ-033 ex_mem_read=1, ex_dest=7, ADD src1=7 -> stall=1, in_ready=0, bubble; next cycle ex_mem_read=0 -> ADD issues; ex_dest=0 -> no stall.
REQ-034 Stall and flush same cycle -> bubble, in_ready=1, stall=0, instruction dropped.
REQ-035 Opcode 63 -> out_valid=1, controls 0, illegal=1 for one cycle; opcode 0 -> illegal=0.
REQ-036 MULT_EN, MUL_LAT=4, opcode 4 -> 3 bubbles, in_ready=0, then exe_cmd=3 wb_en=1; flush on bubble 2 -> IDLE, no MUL issued; without MULT_EN -> illegal=1.
